// File: rtl/equiv_stim_gen_if.sv
// rtl/equiv_stim_gen_if.sv - stimulus bus between the generator and the equivalence harness
// The generator drives wire0..wire4/valid and receives the harness mismatch flag.
interface equiv_stim_gen_if;
  logic        [10:0] wire0;
  logic        [11:0] wire1;
  logic signed [9:0]  wire2;
  logic        [8:0]  wire3;
  logic signed [10:0] wire4;
  logic               valid;
  logic               mismatch_in;

  modport master (
    output wire0, wire1, wire2, wire3, wire4, valid,
    input  mismatch_in
  );

  modport slave (
    input  wire0, wire1, wire2, wire3, wire4, valid,
    output mismatch_in
  );
endinterface

// File: rtl/equiv_stim_gen.sv
// rtl/equiv_stim_gen.sv - LFSR stimulus initiator for the two-implementation equivalence harness
// Issues num_vec vectors, drains for DRAIN cycles, and reports the first mismatch index.
module equiv_stim_gen #(
  parameter logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF,
  parameter int          CNT_W = 16,
  parameter int          DRAIN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              seed_ld,
  input  logic [63:0]       seed_in,
  input  logic [CNT_W-1:0]  num_vec,
  equiv_stim_gen_if.master  stim,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_idx,
  output logic [CNT_W-1:0]  vec_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN);

  logic [1:0]        state_q, state_d;
  logic [63:0]       lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  fidx_q, fidx_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              fail_q, fail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [10:0]       w0_q, w0_d;
  logic [11:0]       w1_q, w1_d;
  logic [9:0]        w2_q, w2_d;
  logic [8:0]        w3_q, w3_d;
  logic [10:0]       w4_q, w4_d;

  assign lfsr_step = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    drain_d = drain_q;
    fail_d  = fail_q;
    valid_d = valid_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    w4_d    = w4_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        // Seed load lands in lfsr_q before the first RUN edge, so start+seed_ld uses the new seed.
        if (seed_ld) begin
          lfsr_d = (seed_in == 64'd0) ? SEED : seed_in;
        end
        if (start) begin
          fail_d = 1'b0;
          cnt_d  = '0;
          if (num_vec != '0) begin
            num_d   = num_vec;
            fidx_d  = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        w0_d    = lfsr_q[10:0];
        w1_d    = lfsr_q[22:11];
        w2_d    = lfsr_q[32:23];
        w3_d    = lfsr_q[41:33];
        w4_d    = lfsr_q[52:42];
        valid_d = 1'b1;
        lfsr_d  = lfsr_step;
        cnt_d   = cnt_inc;
        if (cnt_inc == num_q) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        drain_d = drain_q + 1'b1;
        if (drain_q == DW'(DRAIN - 1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Only the first mismatch of a run records its index.
    if ((state_q == S_RUN || state_q == S_DRAIN) && stim.mismatch_in && !fail_q) begin
      fail_d = 1'b1;
      fidx_d = cnt_q;
    end
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      num_q   <= '0;
      cnt_q   <= '0;
      fidx_q  <= '0;
      drain_q <= '0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      w4_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      drain_q <= drain_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      w4_q    <= w4_d;
    end
  end

  assign stim.wire0 = w0_q;
  assign stim.wire1 = w1_q;
  assign stim.wire2 = w2_q;
  assign stim.wire3 = w3_q;
  assign stim.wire4 = w4_q;
  assign stim.valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_idx   = fidx_q;
  assign vec_cnt    = cnt_q;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// tb/tb_equiv_stim_gen.sv - directed scoreboard bench for equiv_stim_gen
// Expected vectors come from a bench-side LFSR model queued at each start.
module tb_equiv_stim_gen;
  localparam logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF;
  localparam int          CNT_W = 16;
  localparam int          DRAIN = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              seed_ld;
  logic [63:0]       seed_in;
  logic [CNT_W-1:0]  num_vec;
  logic              busy, done, fail;
  logic [CNT_W-1:0]  fail_idx, vec_cnt;

  equiv_stim_gen_if sif ();

  equiv_stim_gen #(.SEED(SEED), .CNT_W(CNT_W), .DRAIN(DRAIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed_ld  (seed_ld),
    .seed_in  (seed_in),
    .num_vec  (num_vec),
    .stim     (sif),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_idx (fail_idx),
    .vec_cnt  (vec_cnt)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [52:0]  exp_q[$];
  logic [63:0]  model;

  function automatic logic [63:0] step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  function automatic logic [52:0] slice(input logic [63:0] l);
    return {l[52:42], l[41:33], l[32:23], l[22:11], l[10:0]};
  endfunction

  function automatic logic [52:0] observed_vec();
    return {sif.wire4, sif.wire3, sif.wire2, sif.wire1, sif.wire0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_seed(input logic [63:0] s);
    @(negedge clk);
    seed_ld = 1'b1;
    seed_in = s;
    @(negedge clk);
    seed_ld = 1'b0;
    model = (s == 64'd0) ? SEED : s;
  endtask

  // One full run: optional same-cycle seed load, mismatch pulses where mask[vec_cnt]
  // is set, and optional start/seed_ld pokes while RUN is active.
  task automatic run(input int num, input logic [15:0] mask, input bit poke,
                     input bit do_seed, input logic [63:0] seed, input string tag);
    bit   exp_fail = 0;
    int   exp_idx  = 0;
    int   nvalid   = 0;
    int   last_v   = 0;
    int   done_cyc = 0;
    bit   done_seen = 0;
    for (int i = 0; i <= num && i < 16; i++) begin
      if (mask[i] && !exp_fail) begin
        exp_fail = 1;
        exp_idx  = i;
      end
    end
    if (do_seed) model = (seed == 64'd0) ? SEED : seed;
    for (int k = 0; k < num; k++) begin
      exp_q.push_back(slice(model));
      model = step(model);
    end
    @(negedge clk);
    start   = 1'b1;
    num_vec = CNT_W'(num);
    if (do_seed) begin
      seed_ld = 1'b1;
      seed_in = seed;
    end
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      seed_ld = 1'b0;
      num_vec = 16'd7;
      if (poke && cyc == 2) begin
        start   = 1'b1;
        seed_ld = 1'b1;
        seed_in = 64'hFFFF;
      end
      if (sif.valid) begin
        nvalid++;
        last_v = cyc;
        if (exp_q.size() == 0) check({tag, "_extra_valid"}, 64'd1, 64'd0);
        else check($sformatf("%s_vec%0d", tag, nvalid), 64'(observed_vec()), 64'(exp_q.pop_front()));
      end
      sif.mismatch_in = busy && (vec_cnt < 16) && mask[vec_cnt[3:0]];
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        break;
      end
    end
    sif.mismatch_in = 1'b0;
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    check({tag, "_nvalid"}, 64'(nvalid), 64'(num));
    check({tag, "_vec_cnt"}, 64'(vec_cnt), 64'(num));
    check({tag, "_fail"}, 64'(fail), 64'(exp_fail));
    if (num > 0) begin
      check({tag, "_fail_idx"}, 64'(fail_idx), 64'(exp_idx));
      check({tag, "_done_lat"}, 64'(done_cyc - last_v), 64'(DRAIN + 1));
    end else begin
      check({tag, "_done_lat"}, 64'(done_cyc), 64'd2);
    end
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int done_cnt;
    rst_n           = 1'b0;
    start           = 1'b0;
    seed_ld         = 1'b0;
    seed_in         = 64'd0;
    num_vec         = '0;
    sif.mismatch_in = 1'b0;
    model           = SEED;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(sif.valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fail", 64'(fail), 64'd0);
    check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
    check("rst_fail_idx", 64'(fail_idx), 64'd0);
    check("rst_wires", 64'(observed_vec()), 64'd0);
    rst_n = 1'b1;

    run(1, 16'h0000, 0, 0, 64'd0, "default_seed");
    load_seed(64'd1);
    run(3, 16'h0000, 0, 0, 64'd0, "seed1_n3");
    run(0, 16'h0000, 0, 0, 64'd0, "zero_vec");
    load_seed(64'd1);
    run(5, 16'h0014, 1, 0, 64'd0, "mismatch_poke");
    load_seed(64'd0);
    run(2, 16'h0000, 0, 0, 64'd0, "zero_seed");
    run(4, 16'h0001, 0, 0, 64'd0, "continue_seq");
    run(3, 16'h0000, 0, 1, 64'hDEAD_BEEF_1234_5678, "seed_with_start");

    // Mid-run asynchronous reset.
    @(negedge clk);
    start   = 1'b1;
    num_vec = 16'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(sif.valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_vec_cnt", 64'(vec_cnt), 64'd0);
    check("async_wires", 64'(observed_vec()), 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("reset_no_done", 64'(done_cnt), 64'd0);
    check("reset_idle", 64'(busy), 64'd0);
    model = SEED;
    run(1, 16'h0000, 0, 0, 64'd0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
